// File: rtl/e_mdu_ctrl.sv
// Execute-stage multiply/divide sequencer owning HI/LO, with a busy counter and decode stall.
// Optional madd accumulate (op 9) is built only when MDU_MADD_EN is defined.
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op_E,
  input  logic [31:0] rs_val_E,
  input  logic [31:0] rt_val_E,
  input  logic        md_D,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data_E,
  output logic        dbg_state_o
);

  // Handshake: an op is taken only when start=1 (IDLE and mult/div class);
  // the decode stage must hold any HI/LO op while stall_md=1.
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
  logic        wr_pend_q, wr_pend_d;

  logic        is_mul, is_div, is_madd;
  logic [63:0] prod_s, prod_u, madd_sum;
  logic [31:0] rs_abs, rt_abs, rt_abs_safe, rt_safe;
  logic [31:0] q_mag, r_mag, div_q, div_r, divu_q, divu_r;

`ifdef MDU_MADD_EN
  assign is_madd  = (mdu_op_E == 4'd9);
  assign madd_sum = {hi_q, lo_q} + prod_s;
`else
  assign is_madd  = 1'b0;
  assign madd_sum = 64'd0;
`endif

  assign is_mul = (mdu_op_E == 4'd1) || (mdu_op_E == 4'd2) || is_madd;
  assign is_div = (mdu_op_E == 4'd3) || (mdu_op_E == 4'd4);

  assign prod_s = {{32{rs_val_E[31]}}, rs_val_E} * {{32{rt_val_E[31]}}, rt_val_E};
  assign prod_u = {32'd0, rs_val_E} * {32'd0, rt_val_E};

  // Signed divide on magnitudes; a zero divisor is replaced by 1 so the
  // datapath stays defined, and the commit is suppressed via wr_pend.
  assign rs_abs      = rs_val_E[31] ? -rs_val_E : rs_val_E;
  assign rt_abs      = rt_val_E[31] ? -rt_val_E : rt_val_E;
  assign rt_abs_safe = (rt_val_E == 32'd0) ? 32'd1 : rt_abs;
  assign rt_safe     = (rt_val_E == 32'd0) ? 32'd1 : rt_val_E;
  assign q_mag       = rs_abs / rt_abs_safe;
  assign r_mag       = rs_abs % rt_abs_safe;
  assign div_q       = (rs_val_E[31] ^ rt_val_E[31]) ? -q_mag : q_mag;
  assign div_r       = rs_val_E[31] ? -r_mag : r_mag;
  assign divu_q      = rs_val_E / rt_safe;
  assign divu_r      = rs_val_E % rt_safe;

  assign start     = (state_q == S_IDLE) && (is_mul || is_div);
  assign busy      = (state_q == S_BUSY);
  assign stall_md  = md_D & (start | busy);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mf_data_E = (mdu_op_E == 4'd7) ? hi_q :
                     (mdu_op_E == 4'd8) ? lo_q : 32'd0;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    wr_pend_d = wr_pend_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_BUSY;
          cnt_d     = is_div ? DIV_CNT : MULT_CNT;
          wr_pend_d = 1'b1;
          case (mdu_op_E)
            4'd1: {hi_pend_d, lo_pend_d} = prod_s;
            4'd2: {hi_pend_d, lo_pend_d} = prod_u;
            4'd3: begin
              {hi_pend_d, lo_pend_d} = {div_r, div_q};
              wr_pend_d = (rt_val_E != 32'd0);
            end
            4'd4: begin
              {hi_pend_d, lo_pend_d} = {divu_r, divu_q};
              wr_pend_d = (rt_val_E != 32'd0);
            end
            default: {hi_pend_d, lo_pend_d} = madd_sum;
          endcase
        end else if (mdu_op_E == 4'd5) begin
          hi_d = rs_val_E;
        end else if (mdu_op_E == 4'd6) begin
          lo_d = rs_val_E;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          if (wr_pend_q) begin
            hi_d = hi_pend_q;
            lo_d = lo_pend_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      hi_pend_q <= 32'd0;
      lo_pend_q <= 32'd0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
      wr_pend_q <= wr_pend_d;
    end
  end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Bench for e_mdu_ctrl: fixed vector table, reset corner sequence, then random ops
// checked against an arithmetic reference model. Honors MDU_MADD_EN if defined.
module tb_e_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdu_op_E;
  logic [31:0] rs_val_E, rt_val_E;
  logic        md_D;
  logic        start, busy, stall_md, dbg_state;
  logic [31:0] hi, lo, mf_data_E;

  int errors = 0;
  int checks = 0;
  logic [31:0] cur_hi, cur_lo;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        md;
    logic        exp_start;
    int          lat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[17];

  e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .mdu_op_E(mdu_op_E), .rs_val_E(rs_val_E),
    .rt_val_E(rt_val_E), .md_D(md_D), .start(start), .busy(busy),
    .stall_md(stall_md), .hi(hi), .lo(lo), .mf_data_E(mf_data_E),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mf_exp(input logic [3:0] op);
    if (op == 4'd7) return cur_hi;
    if (op == 4'd8) return cur_lo;
    return 32'd0;
  endfunction

  // Reference: result of one op given the committed HI/LO, from plain arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] h, input logic [31:0] l,
                                output logic st, output int lat,
                                output logic [31:0] nh, output logic [31:0] nl);
    longint a, b, p;
    logic [63:0] u;
    st = 1'b0; lat = 0; nh = h; nl = l;
    case (op)
      4'd1: begin
        p = longint'($signed(rs)) * longint'($signed(rt));
        {nh, nl} = p; st = 1'b1; lat = MC;
      end
      4'd2: begin
        u = 64'(rs) * 64'(rt);
        {nh, nl} = u; st = 1'b1; lat = MC;
      end
      4'd3: begin
        st = 1'b1; lat = DC;
        if (rt != 32'd0) begin
          a = longint'($signed(rs)); b = longint'($signed(rt));
          nl = 32'(a / b); nh = 32'(a % b);
        end
      end
      4'd4: begin
        st = 1'b1; lat = DC;
        if (rt != 32'd0) begin
          nl = rs / rt; nh = rs % rt;
        end
      end
      4'd5: nh = rs;
      4'd6: nl = rs;
`ifdef MDU_MADD_EN
      4'd9: begin
        p = longint'($signed(rs)) * longint'($signed(rt));
        {nh, nl} = {h, l} + 64'(p); st = 1'b1; lat = MC;
      end
`endif
      default: ;
    endcase
  endfunction

  // Presents one op in the current cycle, walks the busy period with noise on the
  // inputs, and checks the committed result in the cycle after.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic md, input logic exp_start,
                       input int lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [3:0] bop;
    mdu_op_E = op; rs_val_E = rs; rt_val_E = rt; md_D = md;
    #1;
    check({name, ".start"}, start, exp_start);
    check({name, ".busy0"}, busy, 1'b0);
    check({name, ".stall0"}, stall_md, md & exp_start);
    check({name, ".mf0"}, mf_data_E, mf_exp(op));
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      bop = 4'($urandom_range(0, 8));
      mdu_op_E = bop; rs_val_E = $urandom; rt_val_E = $urandom;
      #1;
      check($sformatf("%s.busy@%0d", name, k), busy, 1'b1);
      check($sformatf("%s.start@%0d", name, k), start, 1'b0);
      check($sformatf("%s.stall@%0d", name, k), stall_md, md);
      check($sformatf("%s.hi@%0d", name, k), hi, cur_hi);
      check($sformatf("%s.lo@%0d", name, k), lo, cur_lo);
      check($sformatf("%s.mf@%0d", name, k), mf_data_E, mf_exp(bop));
    end
    @(posedge clk); #1;
    mdu_op_E = 4'd0;
    #1;
    check({name, ".busy_end"}, busy, 1'b0);
    check({name, ".stall_end"}, stall_md, 1'b0);
    check({name, ".hi"}, hi, exp_hi);
    check({name, ".lo"}, lo, exp_lo);
    cur_hi = exp_hi; cur_lo = exp_lo;
  endtask

  initial begin
    logic st;
    int lat;
    logic [31:0] nh, nl, rs, rt;
    logic [3:0] op;
    int r;

    vecs[0]  = '{4'd1, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b1, MC, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1, MC, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, DC, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{4'd4, 32'd7, 32'd0, 1'b1, 1'b1, DC, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, DC, 32'h00000000, 32'h80000000};
    vecs[5]  = '{4'd5, 32'h12345678, 32'd0, 1'b0, 1'b0, 0, 32'h12345678, 32'h80000000};
    vecs[6]  = '{4'd7, 32'd0, 32'd0, 1'b1, 1'b0, 0, 32'h12345678, 32'h80000000};
    vecs[7]  = '{4'd6, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0, 0, 32'h12345678, 32'hA5A5A5A5};
    vecs[8]  = '{4'd8, 32'd0, 32'd0, 1'b1, 1'b0, 0, 32'h12345678, 32'hA5A5A5A5};
    vecs[9]  = '{4'd4, 32'd100, 32'd7, 1'b1, 1'b1, DC, 32'h00000002, 32'h0000000E};
    vecs[10] = '{4'd3, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b1, DC, 32'h00000001, 32'hFFFFFFFD};
    vecs[11] = '{4'd15, 32'd1, 32'd1, 1'b1, 1'b0, 0, 32'h00000001, 32'hFFFFFFFD};
    vecs[12] = '{4'd5, 32'd0, 32'd0, 1'b0, 1'b0, 0, 32'h00000000, 32'hFFFFFFFD};
    vecs[13] = '{4'd6, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 0, 32'h00000000, 32'hFFFFFFFF};
`ifdef MDU_MADD_EN
    vecs[14] = '{4'd9, 32'd1, 32'd1, 1'b1, 1'b1, MC, 32'h00000001, 32'h00000000};
`else
    vecs[14] = '{4'd9, 32'd1, 32'd1, 1'b1, 1'b0, 0, 32'h00000000, 32'hFFFFFFFF};
`endif
    vecs[15] = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1, MC, 32'h3FFFFFFF, 32'h00000001};
    vecs[16] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, MC, 32'hFFFFFFFE, 32'h00000001};

    // Reset state
    reset = 1'b1; mdu_op_E = 4'd0; rs_val_E = 32'd0; rt_val_E = 32'd0; md_D = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst.busy", busy, 1'b0);
    check("rst.start", start, 1'b0);
    check("rst.stall", stall_md, 1'b0);
    check("rst.hi", hi, 32'd0);
    check("rst.lo", lo, 32'd0);
    check("rst.mf", mf_data_E, 32'd0);
    cur_hi = 32'd0; cur_lo = 32'd0;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].md,
            vecs[i].exp_start, vecs[i].lat, vecs[i].exp_hi, vecs[i].exp_lo);

    // Reset in the middle of a divide discards the pending result
    mdu_op_E = 4'd3; rs_val_E = 32'd1000; rt_val_E = 32'd3; md_D = 1'b0;
    #1 check("mrst.start", start, 1'b1);
    @(posedge clk); #1 mdu_op_E = 4'd0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    #1 check("mrst.busy_before", busy, 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check("mrst.busy", busy, 1'b0);
    check("mrst.hi", hi, 32'd0);
    check("mrst.lo", lo, 32'd0);
    cur_hi = 32'd0; cur_lo = 32'd0;
    model(4'd1, 32'hFFFFFFF0, 32'd3, cur_hi, cur_lo, st, lat, nh, nl);
    do_op("post_rst_mult", 4'd1, 32'hFFFFFFF0, 32'd3, 1'b1, st, lat, nh, nl);

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 11);
      op = (r == 10) ? 4'd1 : (r == 11) ? 4'd3 : 4'(r);
      rs = $urandom; rt = $urandom;
      case ($urandom_range(0, 7))
        0: rt = 32'd0;
        1: begin rs = 32'h80000000; rt = 32'hFFFFFFFF; end
        2: rt = 32'($urandom_range(1, 9));
        default: ;
      endcase
      model(op, rs, rt, cur_hi, cur_lo, st, lat, nh, nl);
      do_op($sformatf("rnd%0d_op%0d", i, op), op, rs, rt, 1'($urandom_range(0, 1)), st, lat, nh, nl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
